seg_display_scheduler: RTL and testbench
========================================

# seg_display_scheduler

Sequential front end for the board's six-digit seven-segment display. It arbitrates one shared 8-cycle shift-add-3 (double-dabble) BCD converter between three 8-bit display channels, converting only channels whose value changed. It holds the decoded digits in registers and drives the full 56-bit segment bus, replacing three parallel combinational BCD converters with one sequenced datapath.

## Interface
- No parameters.
- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- data0  in  8  channel 0 value; displayed as 2 digits (tens, ones).
- data1  in  8  channel 1 value; displayed as 2 digits (tens, ones).
- data2  in  8  channel 2 value; displayed as 3 digits (hundreds, tens, ones).
- seven  out  56  registered segment bus, 7 bits per digit, active-low, field bit order g,f,e,d,c,b,a (MSB to LSB).
- busy  out  1  registered; 1 while a conversion is in progress (state ≠ IDLE).
- valid  out  1  registered; 1 once every channel has completed at least one conversion since reset.

## Operation
- Field map:
  - [55:49] ch0 tens; [48:42] ch0 ones.
  - [41:35] ch1 tens; [34:28] ch1 ones.
  - [27:21] constant 7'b1111111 (blank).
  - [20:14] ch2 hundreds; [13:7] ch2 tens; [6:0] ch2 ones.
- ch0 and ch1 hundreds digits are computed and discarded, so values ≥100 show mod 100. No leading-zero blanking.
- Digit encodings:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - codes 10–15 = 1111111
- Per-channel state: snap[ch] (8 bits, last value loaded into the converter) and done[ch] (1 bit).
- dirty[ch] = !done[ch] || (data_ch != snap[ch]), evaluated combinationally every cycle.
- Round-robin pointer ptr (0..2) selects the first dirty channel searching ptr, ptr+1, ptr+2 (mod 3).
- FSM states:
  - IDLE: if any channel is dirty, select ch; latch data_ch into the shift register and into snap[ch]; clear the 12-bit BCD accumulator; clear the iteration counter; go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. After the 8th iteration (counter = 7), go to STORE.
  - STORE: write the encoded digits of ch into its seven fields; set done[ch]; set ptr = (ch+1) mod 3; go to IDLE.
- valid is set on the STORE edge that makes all done[] = 1. It stays 1 until reset.
- Inputs are sampled only in IDLE. A change after that sample leaves the channel dirty, and it is reconverted in a later slot. The value already in flight completes and is stored.
- Fields of channels not being stored hold their values.

## Timing
- Reset (synchronous, takes priority over everything):
  - seven = all ones; busy = 0; valid = 0.
  - state = IDLE; ptr = 0; snap[] = 0; done[] = 0, so all channels are dirty.
  - Reset asserted mid-SHIFT or mid-STORE aborts the conversion with no field write.
- Conversion latency, with IDLE select in cycle n:
  - SHIFT in cycles n+1..n+8.
  - STORE in cycle n+9.
  - New seven field visible from cycle n+10, which is also the next IDLE cycle.
- busy is 1 in cycles n+1..n+9.
- Throughput: one channel per 10 cycles. Minimum full refresh of all three channels is 30 cycles.
- After reset release, the first IDLE cycle selects ch0. Order is ch0, ch1, ch2. valid becomes visible 30 cycles after the first IDLE cycle.
- Simultaneous dirty channels are served strictly round-robin from ptr, with no starvation. Worst-case wait for a dirty channel is 20 cycles plus its own 10.

## Test plan
- Reset, then release with data0=42, data1=7, data2=255. Required:
  - During reset: seven = 56'hFF_FFFF_FFFF_FFFF, busy = 0, valid = 0.
  - valid rises exactly 30 cycles after the first IDLE cycle.
  - ch0 fields = 0011001 / 0100100 ("42").
  - ch1 fields = 1000000 / 1111000 ("07").
  - ch2 fields = 0100100 / 0010010 / 0010010 ("255").
  - [27:21] = 1111111.
- Steady state, change data1 7→99. Required:
  - busy rises on the next cycle.
  - ch1 fields become 0010000 / 0010000 10 cycles after the IDLE sample.
  - ch0 and ch2 fields never toggle.
- Change data0, data1 and data2 in the same cycle with ptr = 2. Required: service order ch2, ch0, ch1, with STOREs spaced 10 cycles apart.
- data0 = 123, then changed to 5 during SHIFT. Required:
  - "23" is stored first.
  - One idle cycle later, reconversion gives "05".
  - done[0] remains 1.
- Assert reset in the 4th SHIFT cycle. Required:
  - Next cycle: seven all ones, busy = 0, valid = 0.
  - After release, a full 3-channel refresh restarts at ch0.
- data2 = 0 and data2 = 200. Required:
  - 0 gives three fields of 1000000.
  - 200 gives 0100100 / 1000000 / 1000000.
  - Confirms no leading-zero blanking and correct add-3 on the boundary values.

Source files
------------

// File: rtl/seg_display_scheduler_if.sv
// Channel values in, decoded segment bus and status out
// for the shared-converter seven-segment display front end.
interface seg_display_scheduler_if;
  logic [7:0]  data0;
  logic [7:0]  data1;
  logic [7:0]  data2;
  logic [55:0] seven;
  logic        busy;
  logic        valid;

  modport master (
    output data0,
    output data1,
    output data2,
    input  seven,
    input  busy,
    input  valid
  );

  modport slave (
    input  data0,
    input  data1,
    input  data2,
    output seven,
    output busy,
    output valid
  );
endinterface

// File: rtl/seg_display_scheduler.sv
// Six-digit display front end: one shift-add-3 BCD converter
// shared round-robin between three channels, only when dirty.
module seg_display_scheduler (
  input  logic                    clock,
  input  logic                    reset,
  seg_display_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    STORE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [1:0]  r_ch;
  logic [7:0]  r_snap0;
  logic [7:0]  r_snap1;
  logic [7:0]  r_snap2;
  logic [2:0]  r_done;
  logic [7:0]  r_bin;
  logic [11:0] r_bcd;
  logic [2:0]  r_cnt;
  logic [55:0] r_seven;
  logic        r_busy;
  logic        r_valid;

  logic [2:0]  w_dirty;
  logic        w_any;
  logic [1:0]  w_sel;
  logic [7:0]  w_data;
  logic [10:0] w_adj;
  logic [2:0]  w_mask;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign w_dirty[0] = !r_done[0] || (bus.data0 != r_snap0);
  assign w_dirty[1] = !r_done[1] || (bus.data1 != r_snap1);
  assign w_dirty[2] = !r_done[2] || (bus.data2 != r_snap2);

  // Walk backwards so the first dirty channel from ptr wins.
  always_comb begin
    logic [2:0] t;
    w_any = 1'b0;
    w_sel = r_ptr;
    for (int k = 2; k >= 0; k--) begin
      t = {1'b0, r_ptr} + 3'(k);
      if (t >= 3'd3) t = t - 3'd3;
      if (w_dirty[t[1:0]]) begin
        w_any = 1'b1;
        w_sel = t[1:0];
      end
    end
  end

  always_comb begin
    case (w_sel)
      2'd0:    w_data = bus.data0;
      2'd1:    w_data = bus.data1;
      default: w_data = bus.data2;
    endcase
  end

  // Hundreds never exceeds 2 for an 8-bit input, so it needs no add-3.
  assign w_adj  = {r_bcd[10:8], add3(r_bcd[7:4]), add3(r_bcd[3:0])};
  assign w_mask = 3'b001 << r_ch;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_ch    <= 2'd0;
      r_snap0 <= 8'd0;
      r_snap1 <= 8'd0;
      r_snap2 <= 8'd0;
      r_done  <= 3'b000;
      r_bin   <= 8'd0;
      r_bcd   <= 12'd0;
      r_cnt   <= 3'd0;
      r_seven <= '1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_ch    <= w_sel;
            r_bin   <= w_data;
            r_bcd   <= 12'd0;
            r_cnt   <= 3'd0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
            case (w_sel)
              2'd0:    r_snap0 <= w_data;
              2'd1:    r_snap1 <= w_data;
              default: r_snap2 <= w_data;
            endcase
          end
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_adj, r_bin, 1'b0};
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) r_state <= STORE;
        end
        STORE: begin
          case (r_ch)
            2'd0: r_seven[55:42] <=
              {seg(r_bcd[7:4]), seg(r_bcd[3:0])};
            2'd1: r_seven[41:28] <=
              {seg(r_bcd[7:4]), seg(r_bcd[3:0])};
            default: r_seven[20:0] <=
              {seg(r_bcd[11:8]), seg(r_bcd[7:4]),
               seg(r_bcd[3:0])};
          endcase
          r_done  <= r_done | w_mask;
          if ((r_done | w_mask) == 3'b111) r_valid <= 1'b1;
          r_ptr   <= (r_ch == 2'd2) ? 2'd0 : r_ch + 2'd1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.seven = r_seven;
  assign bus.busy  = r_busy;
  assign bus.valid = r_valid;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboard bench: stimulus queues expected digits per store,
// a negedge monitor pops and checks on every completed store.
module tb_seg_display_scheduler;

  logic clock = 1'b0;
  logic reset;

  seg_display_scheduler_if bus();

  seg_display_scheduler dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int ch;
    int h;
    int t;
    int o;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;
  logic prev_busy = 1'b0;

  function automatic logic [6:0] enc(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [55:0] act,
                     input logic [55:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int ch, input int h, input int t,
                      input int o);
    exp_t x;
    x.ch = ch;
    x.h  = h;
    x.t  = t;
    x.o  = o;
    q.push_back(x);
  endtask

  // A store is the busy 1->0 transition outside reset.
  always @(negedge clock) begin
    if (!reset && prev_busy && !bus.busy) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_store: got store, expected none");
      end else begin
        e = q.pop_front();
        case (e.ch)
          0: chk("ch0_fields", 56'(bus.seven[55:42]),
                 56'({enc(e.t), enc(e.o)}));
          1: chk("ch1_fields", 56'(bus.seven[41:28]),
                 56'({enc(e.t), enc(e.o)}));
          default: chk("ch2_fields", 56'(bus.seven[20:0]),
                 56'({enc(e.h), enc(e.t), enc(e.o)}));
        endcase
        chk("blank_field", 56'(bus.seven[27:21]), 56'h7F);
      end
    end
    prev_busy = reset ? 1'b0 : bus.busy;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input string nm);
    int i = 0;
    while ((q.size() != 0 || bus.busy) && i < 400) begin
      cyc();
      i++;
    end
    chk(nm, 56'(q.size() != 0 || bus.busy), 56'd0);
    cyc();
  endtask

  task automatic valid_latency(input string nm);
    int vk = -1;
    for (int k = 0; k < 60; k++) begin
      cyc();
      if (k == 0) chk({nm, "_busy_rise"}, 56'(bus.busy), 56'd1);
      if (bus.valid && vk < 0) vk = k;
    end
    chk({nm, "_valid_cycle"}, 56'(vk), 56'd29);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [13:0] f0;
    logic [20:0] f2;
    logic        tog;
    logic        pb;
    int          fl[3];
    int          nf;

    reset     = 1'b1;
    bus.data0 = 8'd42;
    bus.data1 = 8'd7;
    bus.data2 = 8'd255;
    repeat (3) cyc();
    chk("reset_seven", bus.seven, 56'hFF_FFFF_FFFF_FFFF);
    chk("reset_busy", 56'(bus.busy), 56'd0);
    chk("reset_valid", 56'(bus.valid), 56'd0);

    // Initial refresh: 42, 07, 255 in order ch0, ch1, ch2.
    push(0, 0, 4, 2);
    push(1, 0, 0, 7);
    push(2, 2, 5, 5);
    @(negedge clock);
    reset = 1'b0;
    valid_latency("boot");
    wait_done("boot_drain");

    // Single change on ch1; other channels must stay put.
    f0 = bus.seven[55:42];
    f2 = bus.seven[20:0];
    tog = 1'b0;
    @(negedge clock);
    bus.data1 = 8'd99;
    push(1, 0, 9, 9);
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (k == 0) chk("ch1_busy_rise", 56'(bus.busy), 56'd1);
      if (k == 8) chk("ch1_before", 56'(bus.seven[41:28]),
                      56'({enc(0), enc(7)}));
      if (k == 9) chk("ch1_after", 56'(bus.seven[41:28]),
                      56'({enc(9), enc(9)}));
      if (bus.seven[55:42] != f0 || bus.seven[20:0] != f2)
        tog = 1'b1;
    end
    chk("ch0_ch2_hold", 56'(tog), 56'd0);
    wait_done("ch1_drain");

    // ptr is 2 now: all three dirty at once -> ch2, ch0, ch1.
    @(negedge clock);
    bus.data0 = 8'd68;
    bus.data1 = 8'd250;
    bus.data2 = 8'd128;
    push(2, 1, 2, 8);
    push(0, 0, 6, 8);
    push(1, 0, 5, 0);
    pb = 1'b0;
    nf = 0;
    fl = '{-1, -1, -1};
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (pb && !bus.busy && nf < 3) begin
        fl[nf] = k;
        nf++;
      end
      pb = bus.busy;
    end
    chk("rr_store1", 56'(fl[0]), 56'd9);
    chk("rr_store2", 56'(fl[1]), 56'd19);
    chk("rr_store3", 56'(fl[2]), 56'd29);
    wait_done("rr_drain");

    // 123 sampled, then 5 arrives mid-conversion.
    @(negedge clock);
    bus.data0 = 8'd123;
    push(0, 1, 2, 3);
    push(0, 0, 0, 5);
    pb = 1'b0;
    nf = 0;
    fl = '{-1, -1, -1};
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (pb && !bus.busy && nf < 3) begin
        fl[nf] = k;
        nf++;
      end
      pb = bus.busy;
      if (k == 2) begin
        @(negedge clock);
        bus.data0 = 8'd5;
      end
    end
    chk("inflight_store", 56'(fl[0]), 56'd9);
    chk("reconv_store", 56'(fl[1]), 56'd19);
    chk("reconv_count", 56'(nf), 56'd2);
    chk("valid_held", 56'(bus.valid), 56'd1);
    wait_done("inflight_drain");

    // Reset lands in the 4th SHIFT cycle of a ch1 conversion.
    @(negedge clock);
    bus.data1 = 8'd33;
    for (int k = 0; k < 4; k++) cyc();
    @(negedge clock);
    reset = 1'b1;
    cyc();
    chk("abort_seven", bus.seven, 56'hFF_FFFF_FFFF_FFFF);
    chk("abort_busy", 56'(bus.busy), 56'd0);
    chk("abort_valid", 56'(bus.valid), 56'd0);
    cyc();
    push(0, 0, 0, 5);
    push(1, 0, 3, 3);
    push(2, 1, 2, 8);
    @(negedge clock);
    reset = 1'b0;
    valid_latency("restart");
    wait_done("restart_drain");

    // Boundary values on the three-digit channel.
    @(negedge clock);
    bus.data2 = 8'd0;
    push(2, 0, 0, 0);
    wait_done("zero_drain");
    @(negedge clock);
    bus.data2 = 8'd200;
    push(2, 2, 0, 0);
    wait_done("d200_drain");

    repeat (5) cyc();
    chk("queue_empty", 56'(q.size()), 56'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
